// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and control-bundle type for the decode/issue stage.
package cpu_ctrl_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  typedef enum logic [5:0] {
    FN_ADD = 6'b100000,
    FN_SUB = 6'b100010,
    FN_AND = 6'b100100,
    FN_OR  = 6'b100101,
    FN_SLT = 6'b101010
  } funct_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  typedef struct packed {
    alu_op_e    alu_op;
    logic       reg_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic [4:0] rd;
  } ctrl_t;

  // Instruction classes whose rt field is a source operand
  function automatic logic reads_rt(input logic [5:0] opc);
    return (opc == OP_RTYPE) || (opc == OP_BEQ) || (opc == OP_SW);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode into a control bundle.
module ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 6
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic               uses_rt
);

  logic [5:0] opc;
  logic [5:0] funct;
  logic       unused_fields;

  assign opc           = 6'(instr[INSTR_W-1 -: OPC_W]);
  assign funct         = instr[5:0];
  assign unused_fields = ^instr[10:6];
  assign uses_rt       = reads_rt(opc);

  // Decode table; anything unrecognised becomes an all-zero bundle flagged illegal
  always_comb begin
    ctrl = '0;
    case (opc)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.rd        = instr[15:11];
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
          end
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_op     = ALU_ADD;
        ctrl.rd         = instr[20:16];
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.rd        = instr[20:16];
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_stage.sv
// Decode/issue stage: ready/valid handshake, load-use hazard, flush.
// Optional perf counters enabled by defining CTRL_PERF_CNT_EN.
module pipe_ctrl_stage
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned OPC_W   = 6,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned REG_AW  = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_valid,
  output logic               if_ready,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               flush,
  output logic               ex_valid,
  input  logic               ex_ready,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic               ex_reg_write,
  output logic               ex_alu_src,
  output logic               ex_mem_to_reg,
  output logic               ex_mem_write,
  output logic               ex_branch,
  output logic               ex_jump,
  output logic               ex_illegal,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [15:0]        stall_count,
  output logic [15:0]        flush_count
);

  ctrl_t dec_ctrl;
  ctrl_t ex_ctrl;
  logic  dec_uses_rt;
  logic  hazard;
  logic  xfer;

  ctrl_decode #(
    .INSTR_W (INSTR_W),
    .OPC_W   (OPC_W)
  ) u_decode (
    .instr   (if_instr),
    .ctrl    (dec_ctrl),
    .uses_rt (dec_uses_rt)
  );

  // Load-use hazard against the bundle currently held for EX
  always_comb begin
    hazard = ex_valid && ex_ctrl.mem_to_reg && (ex_ctrl.rd != '0) &&
             ((if_instr[25:21] == ex_ctrl.rd) ||
              (dec_uses_rt && (if_instr[20:16] == ex_ctrl.rd)));
  end

  assign if_ready = (!ex_valid || ex_ready) && !hazard && !flush;
  assign xfer     = if_valid && if_ready;

  // Output register: flush wins, then load on transfer, then drain on consume
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (xfer) begin
      ex_valid <= 1'b1;
      ex_ctrl  <= dec_ctrl;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_alu_op     = ALUOP_W'(ex_ctrl.alu_op);
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_branch     = ex_ctrl.branch;
  assign ex_jump       = ex_ctrl.jump;
  assign ex_illegal    = ex_ctrl.illegal;
  assign ex_rd         = REG_AW'(ex_ctrl.rd);

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] flush_q;

  // Saturating stall / flush event counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hazard && if_valid && (stall_q != '1)) stall_q <= stall_q + 16'd1;
      if (flush && (flush_q != '1))              flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_stage.sv
// Self-checking bench for pipe_ctrl_stage: decode table, directed corner
// sequences, then randomized traffic against a behavioural model.
module tb_pipe_ctrl_stage;

`ifdef CTRL_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write, ex_alu_src, ex_mem_to_reg, ex_mem_write;
  logic        ex_branch, ex_jump, ex_illegal;
  logic [4:0]  ex_rd;
  logic [15:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_stage #(
    .INSTR_W (32),
    .OPC_W   (6),
    .ALUOP_W (4),
    .REG_AW  (5)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .if_valid      (if_valid),
    .if_ready      (if_ready),
    .if_instr      (if_instr),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_op     (ex_alu_op),
    .ex_reg_write  (ex_reg_write),
    .ex_alu_src    (ex_alu_src),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_write  (ex_mem_write),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_illegal    (ex_illegal),
    .ex_rd         (ex_rd),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  // Bundle layout: {alu_op[15:12], rw, alu_src, mem_to_reg, mem_write, branch, jump, illegal, rd[4:0]}
  logic [15:0] act;
  assign act = {ex_alu_op, ex_reg_write, ex_alu_src, ex_mem_to_reg, ex_mem_write,
                ex_branch, ex_jump, ex_illegal, ex_rd};

  typedef struct {
    logic [31:0] instr;
    logic [15:0] exp;
  } vec_t;

  localparam logic [31:0] I_ADD = 32'h012A4020;  // add r8, r9, r10
  localparam logic [31:0] I_SUB = 32'h00221822;  // sub r3, r1, r2
  localparam logic [31:0] I_LW9 = 32'h8C290004;  // lw r9, 4(r1)
  localparam logic [15:0] E_ADD = {4'b0010, 7'b1000000, 5'd8};
  localparam logic [15:0] E_SUB = {4'b0110, 7'b1000000, 5'd3};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Decode rules straight from the instruction-set table
  function automatic logic [15:0] ref_decode(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: begin
        case (fn)
          6'h20:   return {4'b0010, 7'b1000000, ins[15:11]};
          6'h22:   return {4'b0110, 7'b1000000, ins[15:11]};
          6'h24:   return {4'b0000, 7'b1000000, ins[15:11]};
          6'h25:   return {4'b0001, 7'b1000000, ins[15:11]};
          6'h2A:   return {4'b0111, 7'b1000000, ins[15:11]};
          default: return {4'b0000, 7'b0000001, 5'd0};
        endcase
      end
      6'h23:   return {4'b0010, 7'b1110000, ins[20:16]};
      6'h2B:   return {4'b0010, 7'b0101000, 5'd0};
      6'h04:   return {4'b0110, 7'b0000100, 5'd0};
      6'h08:   return {4'b0010, 7'b1100000, ins[20:16]};
      6'h02:   return {4'b0000, 7'b0000010, 5'd0};
      default: return {4'b0000, 7'b0000001, 5'd0};
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs, rt, rd;
    case ($urandom_range(0, 8))
      0, 1, 2: op = 6'h00;
      3:       op = 6'h23;
      4:       op = 6'h2B;
      5:       op = 6'h04;
      6:       op = 6'h08;
      7:       op = 6'h02;
      default: op = 6'h3F;
    endcase
    case ($urandom_range(0, 5))
      0:       fn = 6'h20;
      1:       fn = 6'h22;
      2:       fn = 6'h24;
      3:       fn = 6'h25;
      4:       fn = 6'h2A;
      default: fn = 6'h07;
    endcase
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    return {op, rs, rt, rd, 5'($urandom_range(0, 31)), fn};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    if_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Behavioural model state
  logic        m_valid;
  logic [15:0] m_bundle;
  int          m_stall, m_flush;

  function automatic logic model_hazard(input logic [31:0] ins);
    logic       rt_src;
    logic [4:0] r;
    r      = m_bundle[4:0];
    rt_src = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h04) || (ins[31:26] == 6'h2B);
    return m_valid && m_bundle[9] && (r != 5'd0) &&
           ((ins[25:21] == r) || (rt_src && (ins[20:16] == r)));
  endfunction

  vec_t vecs[13];

  initial begin
    logic hz;
    logic exp_ready;

    vecs[0]  = '{I_ADD,        E_ADD};
    vecs[1]  = '{I_SUB,        E_SUB};
    vecs[2]  = '{32'h00222024, {4'b0000, 7'b1000000, 5'd4}};
    vecs[3]  = '{32'h00222825, {4'b0001, 7'b1000000, 5'd5}};
    vecs[4]  = '{32'h0022302A, {4'b0111, 7'b1000000, 5'd6}};
    vecs[5]  = '{I_LW9,        {4'b0010, 7'b1110000, 5'd9}};
    vecs[6]  = '{32'hAC290008, {4'b0010, 7'b0101000, 5'd0}};
    vecs[7]  = '{32'h10220003, {4'b0110, 7'b0000100, 5'd0}};
    vecs[8]  = '{32'h20270005, {4'b0010, 7'b1100000, 5'd7}};
    vecs[9]  = '{32'h08000100, {4'b0000, 7'b0000010, 5'd0}};
    vecs[10] = '{32'hFC221820, {4'b0000, 7'b0000001, 5'd0}};
    vecs[11] = '{32'h00221807, {4'b0000, 7'b0000001, 5'd0}};
    vecs[12] = '{32'h00220020, {4'b0010, 7'b1000000, 5'd0}};

    // Reset is seen before any clock edge
    reset    = 1'b1;
    if_valid = 1'b0;
    if_instr = '0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    #1;
    check("reset_ex_valid", 32'(ex_valid), 32'd0);
    check("reset_bundle",   32'(act),      32'd0);
    check("reset_stall",    32'(stall_count), 32'd0);
    check("reset_flush",    32'(flush_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("post_reset_if_ready", 32'(if_ready), 32'd1);

    // Decode table, one isolated instruction at a time
    for (int i = 0; i < 13; i++) begin
      if_valid = 1'b1;
      if_instr = vecs[i].instr;
      #1;
      check($sformatf("tbl%0d_if_ready", i), 32'(if_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      if_valid = 1'b0;
      #1;
      check($sformatf("tbl%0d_ex_valid", i), 32'(ex_valid), 32'd1);
      check($sformatf("tbl%0d_bundle", i),   32'(act),      32'(vecs[i].exp));
      @(negedge clk);
      #1;
      check($sformatf("tbl%0d_drain", i), 32'(ex_valid), 32'd0);
    end

    // Load-use: LW r9 then ADD reading r9 -> one bubble
    do_reset();
    if_valid = 1'b1;
    if_instr = I_LW9;
    @(posedge clk);
    @(negedge clk);
    if_instr = I_ADD;
    #1;
    check("lu_lw_valid",   32'(ex_valid), 32'd1);
    check("lu_hazard_rdy", 32'(if_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1;
    check("lu_bubble_valid", 32'(ex_valid),    32'd0);
    check("lu_bubble_rdy",   32'(if_ready),    32'd1);
    check("lu_stall_count",  32'(stall_count), 32'(PERF));
    @(posedge clk);
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("lu_add_valid",  32'(ex_valid), 32'd1);
    check("lu_add_bundle", 32'(act),      32'(E_ADD));

    // Backpressure: hold for 3 cycles, then release
    do_reset();
    if_valid = 1'b1;
    if_instr = I_ADD;
    @(posedge clk);
    @(negedge clk);
    ex_ready = 1'b0;
    if_instr = I_SUB;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("bp%0d_if_ready", c), 32'(if_ready), 32'd0);
      check($sformatf("bp%0d_ex_valid", c), 32'(ex_valid), 32'd1);
      check($sformatf("bp%0d_bundle", c),   32'(act),      32'(E_ADD));
      @(posedge clk);
      @(negedge clk);
    end
    ex_ready = 1'b1;
    #1;
    check("bp_release_rdy", 32'(if_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if_valid = 1'b0;
    #1;
    check("bp_next_valid",  32'(ex_valid), 32'd1);
    check("bp_next_bundle", 32'(act),      32'(E_SUB));

    // Flush beats an incoming instruction and a stalled EX
    do_reset();
    if_valid = 1'b1;
    if_instr = I_ADD;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b1;
    ex_ready = 1'b0;
    if_instr = I_SUB;
    #1;
    check("fl_if_ready", 32'(if_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    if_valid = 1'b0;
    ex_ready = 1'b1;
    #1;
    check("fl_ex_valid",    32'(ex_valid),    32'd0);
    check("fl_flush_count", 32'(flush_count), 32'(PERF));

    // Asynchronous reset mid-stream, with a non-zero flush counter pending
    do_reset();
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    if_valid = 1'b1;
    if_instr = I_ADD;
    @(posedge clk);
    @(negedge clk);
    if_valid = 1'b0;
    ex_ready = 1'b0;
    #1;
    check("ar_pre_valid", 32'(ex_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("ar_ex_valid", 32'(ex_valid),    32'd0);
    check("ar_bundle",   32'(act),         32'd0);
    check("ar_flush",    32'(flush_count), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    ex_ready = 1'b1;

    // Randomized traffic against the model
    do_reset();
    m_valid  = 1'b0;
    m_bundle = '0;
    m_stall  = 0;
    m_flush  = 0;
    for (int n = 0; n < 3000; n++) begin
      if_valid = ($urandom_range(0, 3) != 0);
      if_instr = rand_instr();
      ex_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 15) == 0);
      #1;
      hz        = model_hazard(if_instr);
      exp_ready = (!m_valid || ex_ready) && !hz && !flush;
      check("rnd_if_ready", 32'(if_ready), 32'(exp_ready));
      check("rnd_ex_valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid) check("rnd_bundle", 32'(act), 32'(m_bundle));
      check("rnd_stall_count", 32'(stall_count), 32'(PERF * m_stall));
      check("rnd_flush_count", 32'(flush_count), 32'(PERF * m_flush));
      @(posedge clk);
      if (hz && if_valid && m_stall < 65535) m_stall++;
      if (flush && m_flush < 65535) m_flush++;
      if (flush) begin
        m_valid = 1'b0;
      end else if (if_valid && exp_ready) begin
        m_valid  = 1'b1;
        m_bundle = ref_decode(if_instr);
      end else if (ex_ready) begin
        m_valid = 1'b0;
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
